// File: rtl/spc_pkg.sv
// Shared definitions for the spc1 configuration loader: device word width,
// loader state codes and the default strobe length.
package spc_pkg;

    localparam int SPC1_WORD_W        = 11;
    localparam int DEFAULT_STROBE_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_STROBE   = 2'd3
    } spc_state_t;

endpackage

// File: rtl/spc_piso.sv
// Parallel-in/serial-out shadow register: captures the whole configuration
// word on load and presents it LSB-first, shifting right on each shift enable.
module spc_piso #(
    parameter int W = 11
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] shadow_reg;
    logic [W-1:0] shift_next;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == W - 1) begin : g_top
                assign shift_next[gi] = 1'b0;
            end else begin : g_low
                assign shift_next[gi] = shadow_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            shadow_reg <= '0;
        end else if (load) begin
            shadow_reg <= din;
        end else if (shift) begin
            shadow_reg <= shift_next;
        end
    end

    assign dout = shadow_reg[0];

endmodule

// File: rtl/spc_cfg_loader.sv
// Serialises a configuration word onto an spc1 daisy chain with a generated
// shift clock, then strobes the chain so every device latches its word.
module spc_cfg_loader
    import spc_pkg::*;
#(
    parameter int WORD_W     = SPC1_WORD_W,
    parameter int N_CHAIN    = 1,
    parameter int STROBE_LEN = DEFAULT_STROBE_LEN
) (
    input  logic                        Clk,
    input  logic                        Resetn,
    input  logic                        Start,
    input  logic [WORD_W*N_CHAIN-1:0]   Word,
    input  logic                        Abort,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Sclk,
    output logic                        Cfg_out,
    output logic                        Strobe
);

    localparam int TOTAL = WORD_W * N_CHAIN;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

    spc_state_t       state_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [3:0]       strobe_cnt_reg;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_bit;
    logic             strobe_last;

    assign strobe_last = (strobe_cnt_reg == 4'd0);

    // A new load may be captured either from IDLE or on the final strobe edge,
    // which is what lets a held Start run loads back to back.
    assign piso_load  = Start && ((state_reg == ST_IDLE) ||
                        (state_reg == ST_STROBE && strobe_last && !Abort));
    // The shadow advances on the Sclk rising edge, so the next bit is ready
    // to be registered onto Cfg_out when Sclk falls.
    assign piso_shift = (state_reg == ST_SHIFT_HI) && !Abort;

    spc_piso #(.W(TOTAL)) u_piso (
        .Clk    (Clk),
        .Resetn (Resetn),
        .load   (piso_load),
        .shift  (piso_shift),
        .din    (Word),
        .dout   (piso_bit)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            strobe_cnt_reg <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            Sclk           <= 1'b0;
            Cfg_out        <= 1'b0;
            Strobe         <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state_reg != ST_IDLE && Abort) begin
                Sclk      <= 1'b0;
                Strobe    <= 1'b0;
                Cfg_out   <= 1'b0;
                Busy      <= 1'b0;
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (Start) begin
                            Cfg_out     <= Word[0];
                            bit_cnt_reg <= '0;
                            Busy        <= 1'b1;
                            state_reg   <= ST_SHIFT_HI;
                        end
                    end
                    ST_SHIFT_HI: begin
                        Sclk      <= 1'b1;
                        state_reg <= ST_SHIFT_LO;
                    end
                    ST_SHIFT_LO: begin
                        Sclk <= 1'b0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            Strobe         <= 1'b1;
                            strobe_cnt_reg <= 4'(STROBE_LEN - 1);
                            state_reg      <= ST_STROBE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            Cfg_out     <= piso_bit;
                            state_reg   <= ST_SHIFT_HI;
                        end
                    end
                    ST_STROBE: begin
                        if (strobe_last) begin
                            Strobe <= 1'b0;
                            Done   <= 1'b1;
                            if (Start) begin
                                Cfg_out     <= Word[0];
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_SHIFT_HI;
                            end else begin
                                Busy      <= 1'b0;
                                Cfg_out   <= 1'b0;
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            strobe_cnt_reg <= strobe_cnt_reg - 4'd1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spc_cfg_loader.sv
// Randomised and directed checks of the loader against a timeline model of a
// load, with a behavioural spc1 chain capturing the serial stream.
module tb_spc_cfg_loader;

    localparam int T  = 11;
    localparam int L  = 2;
    localparam int T2 = 22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [10:0] word;
    logic        busy, done, sclk, cfg, strobe;
    logic        start2, abort2;
    logic [21:0] word2;
    logic        busy2, done2, sclk2, cfg2, strobe2;

    always #5 clk = ~clk;

    spc_cfg_loader dut (
        .Clk(clk), .Resetn(rst_n), .Start(start), .Word(word), .Abort(abort),
        .Busy(busy), .Done(done), .Sclk(sclk), .Cfg_out(cfg), .Strobe(strobe)
    );

    spc_cfg_loader #(.N_CHAIN(2)) dut2 (
        .Clk(clk), .Resetn(rst_n), .Start(start2), .Word(word2), .Abort(abort2),
        .Busy(busy2), .Done(done2), .Sclk(sclk2), .Cfg_out(cfg2), .Strobe(strobe2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: m_t counts edges since the load was accepted.
    bit          m_active, m_done;
    int          m_t;
    logic [10:0] m_w, m_done_word, exp_latched;
    logic [10:0] chain, latched;
    logic        sclk_prev, strobe_prev;

    logic [21:0] chain2, latched2;
    logic        sclk2_prev, strobe2_prev;
    int          e2, rises2, strobe2_edge, done2_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit a, input logic [10:0] w);
        m_done = 1'b0;
        if (m_active) begin
            if (a) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t == 2*T) exp_latched = m_w;
                if (m_t == 2*T + L) begin
                    m_done      = 1'b1;
                    m_done_word = m_w;
                    if (s) begin
                        m_t = 0;
                        m_w = w;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
        end else if (s) begin
            m_active = 1'b1;
            m_t      = 0;
            m_w      = w;
        end
    endtask

    task automatic step(input bit s, input bit a, input logic [10:0] w, input bit s2);
        bit e_sclk, e_cfg, e_strobe, e_busy;
        int idx;
        start  = s;
        abort  = a;
        word   = w;
        start2 = s2;
        @(posedge clk);
        model_edge(s, a, w);
        e2++;
        @(negedge clk);
        e_busy = m_active;
        e_sclk = m_active && (m_t < 2*T) && (m_t % 2 == 1);
        e_strobe = m_active && (m_t >= 2*T);
        idx = (m_t < 2*T) ? m_t / 2 : T - 1;
        e_cfg = m_active ? m_w[idx] : 1'b0;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("cfg_out", 32'(cfg), 32'(e_cfg));
        chk("strobe", 32'(strobe), 32'(e_strobe));
        chk("sclk_during_strobe", 32'(sclk & strobe), 32'd0);
        if (sclk && !sclk_prev) chain = {cfg, chain[10:1]};
        if (strobe && !strobe_prev) latched = chain;
        sclk_prev   = sclk;
        strobe_prev = strobe;
        chk("spc1_latched", 32'(latched), 32'(exp_latched));
        if (m_done) $display("load complete word=%03h t=%0t", m_done_word, $time);
        if (sclk2 && !sclk2_prev) begin
            chain2 = {cfg2, chain2[21:1]};
            rises2++;
        end
        if (strobe2 && !strobe2_prev) begin
            latched2     = chain2;
            strobe2_edge = e2;
        end
        if (done2) done2_edge = e2;
        sclk2_prev   = sclk2;
        strobe2_prev = strobe2;
    endtask

    initial begin
        logic [10:0] w1;
        bit hold;
        rst_n = 1'b0; start = 0; abort = 0; word = '0;
        start2 = 0; abort2 = 0; word2 = '0;
        m_active = 0; m_done = 0; m_t = 0; m_w = '0; m_done_word = '0;
        exp_latched = '0; chain = '0; latched = '0; sclk_prev = 0; strobe_prev = 0;
        chain2 = '0; latched2 = '0; sclk2_prev = 0; strobe2_prev = 0;
        e2 = 0; rises2 = 0; strobe2_edge = -1; done2_edge = -1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({done, sclk, cfg, strobe}), 32'd0);
        chk("rst_outs2", 32'({busy2, done2, sclk2, cfg2, strobe2}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference load, with a Start pulse while busy.
        w1 = 11'b10101100001;
        step(1, 0, w1, 0);
        repeat (4) step(0, 0, 11'($urandom), 0);
        step(1, 0, 11'($urandom), 0);
        repeat (24) step(0, 0, 11'($urandom), 0);
        chk("ref_word_latched", 32'(latched), 32'(w1));

        // Abort mid-shift: spc1 keeps the previous word.
        step(1, 0, 11'h3C5, 0);
        repeat (8) step(0, 0, 11'($urandom), 0);
        step(0, 1, 11'($urandom), 0);
        repeat (6) step(0, 0, 11'($urandom), 0);
        chk("abort_keeps_latch", 32'(latched), 32'(w1));

        // Asynchronous reset while strobing, then a clean load.
        step(1, 0, 11'h2B7, 0);
        repeat (2*T) step(0, 0, 11'($urandom), 0);
        chk("pre_reset_strobe", 32'(strobe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({busy, done, sclk, cfg, strobe}), 32'd0);
        #1 rst_n = 1'b1;
        m_active = 0;
        m_done   = 0;
        step(1, 0, 11'h61A, 0);
        repeat (26) step(0, 0, 11'($urandom), 0);
        chk("post_reset_latch", 32'(latched), 32'h61A);

        // Two-device chain.
        word2 = 22'h2AA155;
        e2 = -1; rises2 = 0; strobe2_edge = -1; done2_edge = -1;
        step(0, 0, 11'($urandom), 1);
        word2 = 22'($urandom);
        repeat (55) step(0, 0, 11'($urandom), 0);
        chk("chain2_rises", 32'(rises2), 32'(T2));
        chk("chain2_strobe_edge", 32'(strobe2_edge), 32'(2*T2));
        chk("chain2_done_edge", 32'(done2_edge), 32'(2*T2 + L));
        chk("chain2_dev1", 32'(latched2[10:0]), 32'(22'h2AA155 & 22'h7FF));
        chk("chain2_dev0", 32'(latched2[21:11]), 32'(22'h2AA155 >> 11));
        chk("chain2_idle", 32'(busy2), 32'd0);

        // Start held high: back-to-back loads.
        repeat (80) step(1, 0, 11'($urandom), 0);
        repeat (30) step(0, 0, 11'($urandom), 0);

        // Randomised traffic with occasional aborts and held-Start bursts.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) hold = ($urandom_range(0, 2) == 0);
            step(hold || ($urandom_range(0, 12) == 0),
                 ($urandom_range(0, 70) == 0),
                 11'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
